// File: rtl/input_cond_pkg.sv
// Shared defaults and width helpers for the input conditioner slice.
package input_cond_pkg;

  localparam int unsigned DEF_CHANNELS        = 16;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
  localparam logic        DEF_RESET_LEVEL     = 1'b0;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

  // Width of the debounce counter, which counts 0 .. DEBOUNCE_CYCLES-1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Valid/ready event handshake carrying the channel index and edge direction.
interface input_conditioner_if #(
  parameter int unsigned IDX_W = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_channel;
  logic             evt_rising;

  modport master (output evt_valid, output evt_channel, output evt_rising, input evt_ready);
  modport slave  (input evt_valid, input evt_channel, input evt_rising, output evt_ready);
endinterface

// File: rtl/debounce_channel.sv
// One channel: synchronizer chain, stability counter, edge strobes.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic        RESET_LEVEL     = DEF_RESET_LEVEL
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       count;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Change is accepted on the edge where a mismatch has persisted long enough.
  assign change = (s != level) && (count == CNT_LAST);

  // Synchronizer shift chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= {SYNC_STAGES{RESET_LEVEL}};
    else       sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  // Stability counter and debounced level with one-cycle edge strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      level <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= change && !level;
      fall <= change && level;
      if (change) begin
        level <= ~level;
        count <= '0;
      end else if (s == level) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces CHANNELS raw inputs and serialises accepted changes as events.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned CHANNELS        = DEF_CHANNELS,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic        RESET_LEVEL     = DEF_RESET_LEVEL
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] pending,
  output logic                overflow,
  input_conditioner_if.master evt
);

  localparam int unsigned IDX_W = idx_width(CHANNELS);

  logic [CHANNELS-1:0] change;
  logic [CHANNELS-1:0] dir;
  logic [CHANNELS-1:0] dir_next;
  logic [CHANNELS-1:0] clear;
  logic [CHANNELS-1:0] avail;
  logic [IDX_W-1:0]    sel;
  logic                found;
  logic                accept;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .raw   (raw_in[i]),
      .level (level_out[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i]),
      .change(change[i])
    );
  end

  assign accept = evt.evt_valid && evt.evt_ready;

  // Acceptance clear mask, next direction, and lowest-index selection among
  // pending bits that survive this edge. Selection ignores bits being set on
  // this same edge so a new event appears one cycle after its pending bit.
  always_comb begin
    clear = '0;
    if (accept) clear[evt.evt_channel] = 1'b1;
    dir_next = (dir & ~change) | (~level_out & change);
    avail    = pending & ~clear;
    sel      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (avail[i] && !found) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

  // Pending/direction bookkeeping, sticky overflow and the event register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending         <= '0;
      dir             <= '0;
      overflow        <= 1'b0;
      evt.evt_valid   <= 1'b0;
      evt.evt_channel <= '0;
      evt.evt_rising  <= 1'b0;
    end else begin
      pending  <= avail | change;
      dir      <= dir_next;
      overflow <= overflow | (|(change & avail));
      if (!evt.evt_valid || accept) begin
        evt.evt_valid   <= found;
        evt.evt_channel <= found ? sel : '0;
        evt.evt_rising  <= found ? dir_next[sel] : 1'b0;
      end else begin
        // Held event: channel frozen, direction follows an overwrite.
        evt.evt_rising <= dir_next[evt.evt_channel];
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with CHANNELS=16, SYNC=2, DEBOUNCE=4.
module tb_input_conditioner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] raw_in = '0;
  logic [15:0] level_out, rise_pulse, fall_pulse, pending;
  logic        overflow;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        seen;

  input_conditioner_if #(.IDX_W(4)) evt ();

  input_conditioner #(
    .CHANNELS       (16),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .pending   (pending),
    .overflow  (overflow),
    .evt       (evt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    evt.evt_ready = 1'b0;

    // Reset state
    tick(2);
    check("rst_level", 32'(level_out), 32'h0);
    check("rst_pend", 32'(pending), 32'h0);
    check("rst_valid", 32'(evt.evt_valid), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    tick(3);
    check("idle_pend", 32'(pending), 32'h0);

    // Clean rise on channel 3: level changes 6 edges after raw
    raw_in[3] = 1'b1;
    tick(5);
    check("c3_lvl_at5", 32'(level_out), 32'h0);
    tick(1);
    check("c3_lvl_at6", 32'(level_out), 32'h0008);
    check("c3_rise", 32'(rise_pulse), 32'h0008);
    check("c3_pend", 32'(pending), 32'h0008);
    check("c3_valid_early", 32'(evt.evt_valid), 32'h0);
    tick(1);
    check("c3_rise_gone", 32'(rise_pulse), 32'h0);
    check("c3_valid", 32'(evt.evt_valid), 32'h1);
    check("c3_chan", 32'(evt.evt_channel), 32'd3);
    check("c3_rising", 32'(evt.evt_rising), 32'h1);
    evt.evt_ready = 1'b1;
    tick(1);
    evt.evt_ready = 1'b0;
    check("c3_acc_valid", 32'(evt.evt_valid), 32'h0);
    check("c3_acc_pend", 32'(pending), 32'h0);

    // Glitch of 3 cycles on channel 0 is rejected
    raw_in[0] = 1'b1;
    tick(3);
    raw_in[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen | rise_pulse[0] | fall_pulse[0] | pending[0] | evt.evt_valid;
    end
    check("glitch_seen", 32'(seen), 32'h0);
    check("glitch_lvl", 32'(level_out), 32'h0008);

    // Channels 2 and 7 together, consumer stalled 10 cycles
    raw_in[2] = 1'b1;
    raw_in[7] = 1'b1;
    tick(6);
    check("c27_pend", 32'(pending), 32'h0084);
    check("c27_lvl", 32'(level_out), 32'h008C);
    tick(1);
    check("c27_chan", 32'(evt.evt_channel), 32'd2);
    tick(9);
    check("c27_hold_valid", 32'(evt.evt_valid), 32'h1);
    check("c27_hold_chan", 32'(evt.evt_channel), 32'd2);
    check("c27_hold_pend", 32'(pending), 32'h0084);
    evt.evt_ready = 1'b1;
    tick(1);
    evt.evt_ready = 1'b0;
    check("c27_next_valid", 32'(evt.evt_valid), 32'h1);
    check("c27_next_chan", 32'(evt.evt_channel), 32'd7);
    check("c27_next_pend", 32'(pending), 32'h0080);
    evt.evt_ready = 1'b1;
    tick(1);
    evt.evt_ready = 1'b0;
    check("c27_done", 32'(evt.evt_valid), 32'h0);

    // Channel 5 rises then falls before acceptance: overflow, dir overwrite
    raw_in[5] = 1'b1;
    tick(7);
    check("c5_chan", 32'(evt.evt_channel), 32'd5);
    check("c5_rising", 32'(evt.evt_rising), 32'h1);
    check("c5_ovf0", 32'(overflow), 32'h0);
    raw_in[5] = 1'b0;
    tick(6);
    check("c5_fall", 32'(fall_pulse), 32'h0020);
    check("c5_ovf", 32'(overflow), 32'h1);
    check("c5_dir", 32'(evt.evt_rising), 32'h0);
    check("c5_pend", 32'(pending), 32'h0020);
    check("c5_hold_chan", 32'(evt.evt_channel), 32'd5);
    evt.evt_ready = 1'b1;
    tick(1);
    evt.evt_ready = 1'b0;
    check("c5_acc_pend", 32'(pending), 32'h0);
    check("c5_acc_valid", 32'(evt.evt_valid), 32'h0);

    // Four channels together, ready held: one event per cycle, ascending
    raw_in[9]  = 1'b1;
    raw_in[10] = 1'b1;
    raw_in[12] = 1'b1;
    raw_in[15] = 1'b1;
    evt.evt_ready = 1'b1;
    tick(6);
    check("q4_pend", 32'(pending), 32'h9600);
    tick(1);
    check("q4_e0", {evt.evt_valid, 27'h0, evt.evt_channel}, {1'b1, 27'h0, 4'd9});
    tick(1);
    check("q4_e1", {evt.evt_valid, 27'h0, evt.evt_channel}, {1'b1, 27'h0, 4'd10});
    tick(1);
    check("q4_e2", {evt.evt_valid, 27'h0, evt.evt_channel}, {1'b1, 27'h0, 4'd12});
    tick(1);
    check("q4_e3", {evt.evt_valid, 27'h0, evt.evt_channel}, {1'b1, 27'h0, 4'd15});
    tick(1);
    check("q4_drain", 32'(evt.evt_valid), 32'h0);
    check("q4_pend0", 32'(pending), 32'h0);
    check("q4_ovf_sticky", 32'(overflow), 32'h1);
    evt.evt_ready = 1'b0;

    // Reset at count 3 of channel 1 debounce
    raw_in[1] = 1'b1;
    tick(5);
    reset = 1'b1;
    #1;
    check("mid_rst_lvl", 32'(level_out), 32'h0);
    check("mid_rst_ovf", 32'(overflow), 32'h0);
    check("mid_rst_valid", 32'(evt.evt_valid), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(5);
    check("post_rst_lvl5", 32'(level_out), 32'h0);
    check("post_rst_pend5", 32'(pending), 32'h0);
    tick(1);
    check("post_rst_lvl6", 32'(level_out), 32'h968E);
    check("post_rst_pend6", 32'(pending), 32'h968E);
    tick(1);
    check("post_rst_chan", 32'(evt.evt_channel), 32'd1);
    check("post_rst_ovf", 32'(overflow), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 16, giving the number of independent switch/button inputs.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2 (min 2), giving the synchronizer flop depth.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000 (min 2), giving the consecutive stable cycles required to accept a change.
REQ-004 The block SHALL have parameter RESET_LEVEL, default 0, giving the value of sync flops and level_out after reset.
REQ-005 The block SHALL derive IDX_W = max(1, clog2(CHANNELS)) and CNT_W = clog2(DEBOUNCE_CYCLES).
REQ-006 clock  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 raw_in  input  CHANNELS  asynchronous raw switch levels.
REQ-009 level_out  output  CHANNELS  debounced, registered levels.
REQ-010 rise_pulse / fall_pulse  output  CHANNELS each  one-cycle strobes marking accepted 0->1 / 1->0 changes.
REQ-011 evt_valid  output  1  an event is presented.
REQ-012 evt_ready  input  1  consumer accepts the presented event.
REQ-013 evt_channel  output  IDX_W  index of the presented event's channel.
REQ-014 evt_rising  output  1  1 = presented event is a rise, 0 = fall.
REQ-015 pending  output  CHANNELS  per-channel unacknowledged-change mask.
REQ-016 overflow  output  1  sticky; set when a change arrives on a channel already pending.

Function
REQ-017 Each channel SHALL pass raw_in[i] through SYNC_STAGES flops to give s[i].
REQ-018 Per channel: s[i]==level_out[i] -> counter cleared; else counter increments; on the edge where the counter equals DEBOUNCE_CYCLES-1, level_out[i] toggles and the counter clears.
REQ-019 Latency raw_in edge -> level_out change SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles for a clean step.
REQ-020 A mismatch shorter than DEBOUNCE_CYCLES cycles SHALL produce no level change, pulse or event.
REQ-021 rise_pulse[i]/fall_pulse[i] SHALL be high for exactly the first cycle level_out[i] shows the new value.
REQ-022 pending[i] SHALL set, and dir[i] SHALL load the new level, on the same edge level_out[i] changes.
REQ-023 evt_valid SHALL rise the cycle after any pending bit is set while no event is presented; selection = lowest-index pending channel.
REQ-024 While evt_valid && !evt_ready, evt_channel and evt_rising SHALL hold stable even if lower-index channels become pending.
REQ-025 On evt_valid && evt_ready, pending[evt_channel] SHALL clear, and the next lowest pending channel SHALL be presented the following cycle (one event per cycle sustained).
REQ-026 Simultaneous set and acceptance on the same channel: set wins; pending stays 1 and dir takes the new level.
REQ-027 A change on a channel whose pending bit is already 1 SHALL set overflow and overwrite dir; if that channel is presented, evt_rising SHALL update to the new dir.
REQ-028 overflow SHALL clear only on reset.
REQ-029 Multiple channels changing on one edge SHALL all set pending; none SHALL be lost.

Reset
REQ-030 Reset assertion SHALL immediately force sync flops and level_out to RESET_LEVEL; counters, pending, dir, pulses, evt_valid, evt_channel, evt_rising and overflow to 0.
REQ-031 Reset mid-debounce SHALL discard partial counts; after release a full SYNC_STAGES+DEBOUNCE_CYCLES is required.
REQ-032 No event SHALL be generated by reset assertion or release itself.

Structure
REQ-033 Default parameter values and the IDX_W/CNT_W width helper SHALL live in shared package input_cond_pkg.
REQ-034 Per-channel synchronizer+debouncer+pulse logic SHALL be sub-module debounce_channel, instantiated CHANNELS times; event arbitration/handshake stays in input_conditioner.

Verification (CHANNELS=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-035 raw_in[3] 0->1 held -> level_out[3]=1 exactly 6 cycles later, rise_pulse[3] high 1 cycle, evt_valid=1 with evt_channel=3, evt_rising=1 next cycle.
REQ-036 raw_in[0] high for 3 cycles then low -> level_out, pulses, pending, evt_valid stay 0.
REQ-037 raw_in[2] and raw_in[7] rise same cycle, evt_ready=0 for 10 cycles -> evt_channel=2 held, pending=0x0084; one ready cycle -> channel 7 presented next cycle.
REQ-038 Channel 5 rises then falls before acceptance -> overflow=1, evt_rising=0, single pending bit.
REQ-039 reset pulsed at count 3 of ch1 debounce -> all outputs 0 immediately; after release change needs full 6 cycles.
REQ-040 Four channels change together, evt_ready held 1 -> four accepted events on four consecutive cycles, indices ascending.
